// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key event queue: parser states,
// prefix byte values and the queued key-event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } parse_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

endpackage

// File: rtl/ps2_key_queue_if.sv
// Valid/ready key-event stream between the queue (master) and its consumer (slave).
interface ps2_key_queue_if;
  import ps2_pkg::*;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;

  modport master (output ev_valid, output ev_code, output ev_ext, output ev_brk, input ev_ready);
  modport slave  (input ev_valid, input ev_code, input ev_ext, input ev_brk, output ev_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// First-word-fall-through key-event FIFO; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  key_event_t                   push_data,
  input  logic                         pop,
  output key_event_t                   head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  key_event_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is forced to zero while empty so the outputs read 0 out of reset.
  assign head = empty ? key_event_t'('0) : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer widths equal log2(DEPTH), so plain increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/ps2_key_queue.sv
// PS/2 scan-byte parser (E0/F0 prefix handling, prefix timeout) feeding a
// key-event FIFO with sticky overflow and bad-input flags.
module ps2_key_queue
  import ps2_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int REPORT_MAKE    = 1,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_ro,
  input  logic                        rx_err,
  input  logic [7:0]                  rx_data,
  ps2_key_queue_if.master             ev,
  output logic [$clog2(DEPTH+1)-1:0]  ev_count,
  output logic                        ovf,
  output logic                        rx_bad,
  input  logic                        clr_flags
);
  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);

  logic          rx_ro_reg;
  parse_state_t  state_reg, state_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          ovf_reg, bad_reg;
  logic          accept;
  logic          evt_push, evt_want, bad_set, ovf_set;
  logic          fifo_pop, fifo_full, fifo_empty;
  key_event_t    evt, head;

  assign accept = rx_ro & ~rx_ro_reg;

  always_comb begin
    state_next = state_reg;
    tmo_next   = tmo_reg;
    evt_push   = 1'b0;
    bad_set    = 1'b0;
    evt        = '0;
    if (accept) begin
      tmo_next = '0;
      if (rx_err) begin
        bad_set    = 1'b1;
        state_next = ST_IDLE;
      end else if (rx_data == PS2_EXT) begin
        if (state_reg == ST_IDLE || state_reg == ST_E0) begin
          state_next = ST_E0;
        end else begin
          bad_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end else if (rx_data == PS2_BRK) begin
        if (state_reg == ST_IDLE)     state_next = ST_F0;
        else if (state_reg == ST_E0)  state_next = ST_E0F0;
        else begin
          bad_set    = 1'b1;
          state_next = ST_IDLE;
        end
      end else begin
        evt_push   = 1'b1;
        evt.ext    = (state_reg == ST_E0) || (state_reg == ST_E0F0);
        evt.brk    = (state_reg == ST_F0) || (state_reg == ST_E0F0);
        evt.code   = rx_data;
        state_next = ST_IDLE;
      end
    end else if (state_reg != ST_IDLE) begin
      // A stalled prefix is abandoned once it has waited PREFIX_TIMEOUT cycles.
      if (tmo_reg == TMO_LAST) begin
        state_next = ST_IDLE;
        tmo_next   = '0;
        bad_set    = 1'b1;
      end else begin
        tmo_next = tmo_reg + TW'(1);
      end
    end
  end

  assign evt_want = evt_push & ((REPORT_MAKE != 0) | evt.brk);
  assign fifo_pop = ev.ev_valid & ev.ev_ready;
  assign ovf_set  = evt_want & fifo_full & ~fifo_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ro_reg <= 1'b1;
      state_reg <= ST_IDLE;
      tmo_reg   <= '0;
      ovf_reg   <= 1'b0;
      bad_reg   <= 1'b0;
    end else begin
      rx_ro_reg <= rx_ro;
      state_reg <= state_next;
      tmo_reg   <= tmo_next;
      ovf_reg   <= ovf_set | (ovf_reg & ~clr_flags);
      bad_reg   <= bad_set | (bad_reg & ~clr_flags);
    end
  end

  ps2_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (evt_want),
    .push_data (evt),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (ev_count)
  );

  assign ev.ev_valid = ~fifo_empty;
  assign ev.ev_code  = head.code;
  assign ev.ev_ext   = head.ext;
  assign ev.ev_brk   = head.brk;
  assign ovf         = ovf_reg;
  assign rx_bad      = bad_reg;

endmodule

// File: tb/tb_ps2_key_queue.sv
// Scoreboard bench: two queue instances (make+break, break-only) share the byte
// stream; a flag-based key model predicts events, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_ps2_key_queue;
  import ps2_pkg::*;

  localparam int DEPTH = 4;
  localparam int P     = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_ro = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       clr_flags = 1'b0;
  logic [2:0] cnt1, cnt2;
  logic       ovf1, ovf2, bad1, bad2;

  ps2_key_queue_if e1();
  ps2_key_queue_if e2();

  always #5 clk = ~clk;

  ps2_key_queue #(.DEPTH(DEPTH), .REPORT_MAKE(1), .PREFIX_TIMEOUT(P)) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_ro(rx_ro), .rx_err(rx_err), .rx_data(rx_data),
    .ev(e1), .ev_count(cnt1), .ovf(ovf1), .rx_bad(bad1), .clr_flags(clr_flags));

  ps2_key_queue #(.DEPTH(DEPTH), .REPORT_MAKE(0), .PREFIX_TIMEOUT(P)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_ro(rx_ro), .rx_err(rx_err), .rx_data(rx_data),
    .ev(e2), .ev_count(cnt2), .ovf(ovf2), .rx_bad(bad2), .clr_flags(clr_flags));

  assign e2.ev_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // 0: ready low, 1: ready high, 2: random per cycle
  int rdy_mode = 0;
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       e1.ev_ready = 1'b0;
      1:       e1.ev_ready = 1'b1;
      default: e1.ev_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model: pending prefix flags and expected event queues {ext,brk,code}
  logic [9:0] q1[$];
  logic [9:0] q2[$];
  bit   pend_ext, pend_brk;
  int   last_acc = 0;
  logic exp_bad = 1'b0;
  logic exp_ovf = 1'b0;

  task automatic model_byte(input logic [7:0] b, input logic err);
    logic [9:0] e;
    if ((pend_ext || pend_brk) && (cyc - last_acc >= P)) begin
      pend_ext = 0; pend_brk = 0; exp_bad = 1'b1;
    end
    last_acc = cyc;
    if (err) begin
      pend_ext = 0; pend_brk = 0; exp_bad = 1'b1;
    end else if (b == 8'hE0 || b == 8'hF0) begin
      if (pend_brk) begin
        pend_ext = 0; pend_brk = 0; exp_bad = 1'b1;
      end else if (b == 8'hE0) pend_ext = 1;
      else pend_brk = 1;
    end else begin
      e = {pend_ext, pend_brk, b};
      pend_ext = 0; pend_brk = 0;
      if (q1.size() == DEPTH && !e1.ev_ready) exp_ovf = 1'b1;
      else q1.push_back(e);
      if (e[8]) q2.push_back(e);
      $display("byte %h err=%0b -> event ext=%0b brk=%0b code=%h", b, err, e[9], e[8], b);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic err, input int hold, input int gap);
    @(posedge clk); #2;
    rx_data = b; rx_err = err; rx_ro = 1'b1;
    model_byte(b, err);
    repeat (hold) @(posedge clk);
    #2;
    rx_ro = 1'b0; rx_err = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #2;
    clr_flags = 1'b1; exp_bad = 1'b0; exp_ovf = 1'b0;
    @(posedge clk); #2;
    clr_flags = 1'b0;
  endtask

  // Monitor: pop and compare whenever a handshake will complete at the next edge
  logic [9:0] cur1, cur2, hold1;
  bit stall1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall1 = 0;
    end else begin
      cur1 = {e1.ev_ext, e1.ev_brk, e1.ev_code};
      cur2 = {e2.ev_ext, e2.ev_brk, e2.ev_code};
      if (stall1) begin
        chk("hold_valid", 32'(e1.ev_valid), 32'd1);
        chk("hold_head", 32'(cur1), 32'(hold1));
      end
      stall1 = e1.ev_valid && !e1.ev_ready;
      hold1  = cur1;
      if (e1.ev_valid && e1.ev_ready) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL ev1_unexpected act=%h exp=none t=%0t", cur1, $time);
        end else begin
          chk("ev1", 32'(cur1), 32'(q1.pop_front()));
        end
      end
      if (e2.ev_valid) begin
        if (q2.size() == 0) begin
          total++; bad++;
          $display("FAIL ev2_unexpected act=%h exp=none t=%0t", cur2, $time);
        end else begin
          chk("ev2", 32'(cur2), 32'(q2.pop_front()));
        end
      end
    end
  end

  logic [7:0] mk [5] = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};

  initial begin
    int w;
    logic [7:0] b;
    // reset state
    #12;
    chk("rst_valid", 32'(e1.ev_valid), 32'd0);
    chk("rst_count", 32'(cnt1), 32'd0);
    chk("rst_code", 32'({e1.ev_ext, e1.ev_brk, e1.ev_code}), 32'd0);
    chk("rst_ovf", 32'(ovf1), 32'd0);
    chk("rst_bad", 32'(bad1), 32'd0);
    @(posedge clk); #2; rst_n = 1'b1;
    rdy_mode = 1;
    repeat (2) @(posedge clk);

    // make/break, then extended break with long held rx_ro
    send_byte(8'h1C, 0, 1, 2);
    send_byte(8'hF0, 0, 1, 2);
    send_byte(8'h1C, 0, 1, 2);
    send_byte(8'hE0, 0, 20, 2);
    send_byte(8'hF0, 0, 20, 2);
    send_byte(8'h75, 0, 20, 4);
    chk("seq_q1_empty", 32'(q1.size()), 32'd0);
    chk("seq_q2_empty", 32'(q2.size()), 32'd0);
    chk("seq_bad", 32'(bad1), 32'(exp_bad));

    // overflow with a stalled consumer
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) send_byte(mk[i], 0, 1, 1);
    repeat (2) @(posedge clk); #2;
    chk("ovf_count", 32'(cnt1), 32'd4);
    chk("ovf_flag", 32'(ovf1), 32'(exp_ovf));
    chk("ovf_head", 32'(e1.ev_code), 32'h15);
    pulse_clr();
    @(posedge clk); #2;
    chk("ovf_cleared", 32'(ovf1), 32'd0);

    // simultaneous push and pop while full
    @(posedge clk); #2; rdy_mode = 1;
    @(posedge clk); #2;
    rx_data = 8'h2E; rx_err = 1'b0; rx_ro = 1'b1;
    model_byte(8'h2E, 0);
    rdy_mode = 0;
    @(posedge clk); #2; rx_ro = 1'b0;
    @(posedge clk); #2;
    chk("full_pp_count", 32'(cnt1), 32'd4);
    chk("full_pp_ovf", 32'(ovf1), 32'd0);
    rdy_mode = 1;
    repeat (8) @(posedge clk);
    chk("full_pp_drain", 32'(q1.size()), 32'd0);

    // prefix timeout and error byte
    send_byte(8'hF0, 0, 1, 0);
    repeat (P + 5) @(posedge clk);
    #2;
    chk("tmo_bad", 32'(bad1), 32'd1);
    send_byte(8'h1C, 0, 1, 3);
    chk("tmo_model_bad", 32'(bad1), 32'(exp_bad));
    pulse_clr();
    @(posedge clk); #2;
    chk("bad_cleared", 32'(bad1), 32'd0);
    send_byte(8'h1C, 1, 1, 3);
    chk("err_bad", 32'(bad1), 32'(exp_bad));
    chk("err_bad2", 32'(bad2), 32'(exp_bad));
    chk("err_noevent", 32'(cnt1), 32'd0);

    // reset mid-sequence with events queued
    rdy_mode = 0;
    send_byte(8'h1C, 0, 1, 1);
    send_byte(8'h32, 0, 1, 1);
    send_byte(8'hE0, 0, 1, 1);
    @(posedge clk); #2;
    chk("pre_rst_count", 32'(cnt1), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(e1.ev_valid), 32'd0);
    chk("mid_rst_count", 32'(cnt1), 32'd0);
    q1.delete(); q2.delete();
    pend_ext = 0; pend_brk = 0; exp_bad = 1'b0; exp_ovf = 1'b0;
    rx_data = 8'h11; rx_ro = 1'b1;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1; rdy_mode = 1;
    repeat (5) @(posedge clk);
    #2; rx_ro = 1'b0;
    repeat (2) @(posedge clk);
    send_byte(8'h75, 0, 1, 4);
    chk("post_rst_q1", 32'(q1.size()), 32'd0);

    // randomized traffic with a randomly stalling consumer
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      w = 0;
      while (q1.size() >= DEPTH && w < 200) begin
        @(posedge clk);
        w++;
      end
      if (w >= 200) begin
        total++; bad++;
        $display("FAIL space_wait act=%0d exp=<%0d", q1.size(), DEPTH);
      end
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_byte(b, ($urandom_range(0, 15) == 0), $urandom_range(1, 4), $urandom_range(1, 3));
    end

    rdy_mode = 1;
    repeat (20) @(posedge clk);
    #2;
    chk("end_q1", 32'(q1.size()), 32'd0);
    chk("end_q2", 32'(q2.size()), 32'd0);
    chk("end_cnt2", 32'(cnt2), 32'd0);
    chk("end_bad1", 32'(bad1), 32'(exp_bad));
    chk("end_bad2", 32'(bad2), 32'(exp_bad));
    chk("end_ovf1", 32'(ovf1), 32'(exp_ovf));
    chk("end_ovf2", 32'(ovf2), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ps2_key_queue.md
PS2_KEY_QUEUE -- requirements
Module: ps2_key_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter REPORT_MAKE, default 1; 1 queues press and release events, 0 queues releases only.
REQ-003 SHALL have parameter PREFIX_TIMEOUT, default 1000000, clk cycles a partial sequence may wait for its next byte.
REQ-004 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: rx_ro  in  1  byte-ready level from PS2 byte receiver (clk domain).
REQ-007 SHALL have ports: rx_err  in  1  parity/framing error, qualifies rx_ro.
REQ-008 SHALL have ports: rx_data  in  8  received scan byte.
REQ-009 SHALL have ports: ev_valid  out  1  FIFO head holds an event.
REQ-010 SHALL have ports: ev_ready  in  1  consumer accepts head.
REQ-011 SHALL have ports: ev_code  out  8  head scan code; ev_ext  out  1  E0-prefixed; ev_brk  out  1  release event.
REQ-012 SHALL have ports: ev_count  out  clog2(DEPTH+1)  entries stored.
REQ-013 SHALL have ports: ovf  out  1  sticky, event dropped on full FIFO; rx_bad  out  1  sticky, error byte or timeout seen.
REQ-014 SHALL have ports: clr_flags  in  1  synchronous clear of ovf and rx_bad.

Function
REQ-015 Byte accepted only in cycle with rx_ro=1 and registered previous rx_ro=0 (rising edge); a held level SHALL be processed once.
REQ-016 Accepted byte with rx_err=1 SHALL be discarded, set rx_bad, return parser to IDLE.
REQ-017 Parser states IDLE, E0, F0, E0F0: IDLE+E0->E0; IDLE+F0->F0; E0+F0->E0F0; E0+E0->E0; F0/E0F0 + E0 or F0 -> IDLE, rx_bad set, no event.
REQ-018 Any other byte: IDLE->event{ext=0,brk=0}; E0->{1,0}; F0->{0,1}; E0F0->{1,1}; code=byte; parser->IDLE.
REQ-019 Make events (brk=0) SHALL be pushed only when REPORT_MAKE=1; break events always.
REQ-020 Byte accepted at edge of cycle N SHALL give ev_valid=1 with that event in cycle N+1 when FIFO was empty.
REQ-021 Timeout counter SHALL run while parser not IDLE, reload on each accepted byte; at PREFIX_TIMEOUT cycles parser->IDLE, rx_bad set.
REQ-022 FIFO first-word-fall-through; pop when ev_valid & ev_ready; ev_* outputs stable while ev_valid=1 and ev_ready=0.
REQ-023 Push when full without simultaneous pop SHALL drop new event, keep stored entries, set ovf.
REQ-024 Push and pop in same cycle when full SHALL both succeed; ev_count unchanged.
REQ-025 Pointers SHALL wrap modulo DEPTH; ev_count in 0..DEPTH.
REQ-026 clr_flags same cycle as a flag-setting event: set wins.

Reset
REQ-027 rst_n low SHALL immediately force: parser IDLE, FIFO empty, ev_valid=0, ev_count=0, ovf=0, rx_bad=0, timeout counter 0, rx_ro edge register 1 (byte already high at release not taken).
REQ-028 ev_code, ev_ext, ev_brk SHALL be 0 in reset; partial sequences lost on reset mid-operation.

Structure
REQ-029 Shared package ps2_pkg SHALL hold parser state enum, constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0, key-event struct {ext, brk, code}.
REQ-030 FIFO SHALL be sub-module ps2_evt_fifo (parameter DEPTH, FWFT, count, full/empty); parser and edge detect in top.

Verification
REQ-031 Bytes 1C, F0, 1C with ev_ready=1 -> events {1C,0,0} then {1C,0,1}; REPORT_MAKE=0 -> only {1C,0,1}.
REQ-032 Bytes E0, F0, 75 -> single event {75,ext=1,brk=1}; rx_ro held high 20 cycles per byte -> no duplicates.
REQ-033 DEPTH=4, ev_ready=0, 5 make events -> ev_count=4, ovf=1, head is first event; then clr_flags -> ovf=0.
REQ-034 Full FIFO, ev_ready=1 and new event same cycle -> ev_count stays 4, order preserved.
REQ-035 Byte F0 then silence PREFIX_TIMEOUT cycles -> rx_bad=1, next 1C yields make {1C,0,0}; rx_err=1 byte -> rx_bad=1, no event.
REQ-036 rst_n low after E0 with 2 events queued -> ev_valid=0, count=0 immediately; next 75 yields {75,0,0}.
